r16_agu: RTL and testbench
==========================

Name: r16_agu

Overview:
- Radix-16 NTT address generator. It is the producer that feeds the index delay pipeline.
- Each issue cycle it emits one conflict-free set of 16 memory-address (MA) and bank-number (BN) indices for one radix-16 butterfly, together with an issue strobe.
- It sequences all STAGES stages of an N = 16^STAGES point transform, inserts stage-gap bubbles for read-after-write safety, drains the downstream pipeline, and then pulses done.

Parameters:
- STAGES, 3, number of radix-16 stages; N = 16^STAGES points (4096 by default).
- GAP_CYC, 12, idle cycles inserted between consecutive stages.
- PIPE_LAT, 12, downstream index-pipeline depth; drain count before done.
- localparam MA_W = 4*(STAGES-1): memory-address width per lane (8 by default).
- localparam J_MAX = 16^(STAGES-1)-1: last butterfly index per stage (255 by default).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- stall  in  1  memory back-pressure; holds issue while high in RUN.
- ma_idx  out  16*MA_W  lane k address at [k*MA_W +: MA_W]; registered.
- bn_idx  out  64  lane k bank at [k*4 +: 4]; registered.
- ntt_enable  out  1  high in each cycle in which ma_idx/bn_idx carry a valid butterfly.
- stage_idx  out  $clog2(STAGES)  stage of the current issue; registered.
- busy  out  1  high in every state except IDLE.
- ntt_done  out  1  one-cycle pulse when the transform is complete.
- intt  in  1  inverse-order select; present only with R16_AGU_INTT_EN.

Behaviour:
- Reset: synchronous, active-high. Next edge forces state IDLE and clears all counters. ma_idx, bn_idx, ntt_enable, stage_idx, busy and ntt_done all become 0. A reset in any state aborts immediately and no done pulse is produced.
- States: IDLE, RUN, GAP, DRAIN.
  - IDLE -> RUN when start=1. Clear s=0, j=0, and capture intt.
  - RUN, stall=0: issue butterfly (s, j) and assert ntt_enable=1 on the next cycle's outputs.
    - If j < J_MAX: j++.
    - If j = J_MAX and s < STAGES-1: go to GAP, j=0, s++.
    - If j = J_MAX and s = STAGES-1: go to DRAIN.
  - RUN, stall=1: ntt_enable=0; j, s, ma_idx and bn_idx hold.
  - GAP: count GAP_CYC cycles with ntt_enable=0, then go to RUN. If GAP_CYC=0, go directly from RUN to RUN.
  - DRAIN: count PIPE_LAT cycles, then pulse ntt_done=1 for exactly one cycle with busy=0 in the same cycle; return to IDLE.
- stall is ignored in IDLE, GAP and DRAIN; those counters keep running.
- start is ignored while busy=1.
- start and stall high together in IDLE: the block still enters RUN, and the first issue waits for stall=0.
- Latency: start sampled at edge t gives the first ntt_enable=1 at the output after edge t+1.
- Total active cycles with no stall: STAGES*(J_MAX+1) + (STAGES-1)*GAP_CYC + PIPE_LAT. With defaults this is 768+24+12 = 804.
- Index arithmetic:
  - Forward digit position: p = STAGES-1-s.
  - Write j in base 16 with STAGES-1 digits. Insert lane number k (0..15) as digit p to form the element index idx_k (4*STAGES bits).
  - BN_k = (sum of all base-16 digits of idx_k) mod 16.
  - MA_k = idx_k >> 4.
  - The 16 BN_k of one issue are always pairwise distinct. The bench checks this on every issue.
- Wrap-around: the BN sum is a 4-bit modulo add with carries discarded. j wraps to 0 only at a stage change.

Optional Feature:
- Macro R16_AGU_INTT_EN.
- Defined: the intt port exists and is captured when leaving IDLE. With intt=1, the digit position is p = s (ascending order from digit 0); everything else is unchanged.
- Undefined: there is no intt port and the order is always forward.

Test Plan:
- Reset, then start, STAGES=3. First issue (s=0, j=0) -> lane k MA=16*k, BN=k, ntt_enable=1 one cycle after start.
- s=0, j=1 -> lane k MA=16*k, BN=(k+1) mod 16. Stage 1, j=0x12 -> lane k MA=0x10+k, BN=(k+3) mod 16. Stage 2, j=0 -> MA=0, BN=k.
- Full run with no stall -> exactly 768 ntt_enable cycles, two 12-cycle gaps, ntt_done at cycle 804 after start, busy low afterward. Every issue has 16 distinct BN values.
- Hold stall=1 for 5 cycles at s=0, j=100 -> outputs hold, ntt_enable=0 for those cycles, then j=100 issues once (no skip, no repeat), and done is delayed by 5 cycles.
- Assert rst at j=50 of stage 1 -> next cycle all outputs 0, state IDLE, no ntt_done. A following start restarts from s=0, j=0.
- With R16_AGU_INTT_EN and intt=1, first issue -> lane k MA=0, BN=k. Start pulsed during RUN is ignored.

Source files
------------

// File: rtl/r16_agu_if.sv
// r16_agu_if: control/handshake and index bus between the radix-16 AGU and its consumers.
// The intt input exists only when R16_AGU_INTT_EN is defined.
interface r16_agu_if #(
    parameter int STAGES = 3
);
    localparam int MA_W = 4 * (STAGES - 1);
    localparam int SW   = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic                 start;
    logic                 stall;
`ifdef R16_AGU_INTT_EN
    logic                 intt;
`endif
    logic [16*MA_W-1:0]   ma_idx;
    logic [63:0]          bn_idx;
    logic                 ntt_enable;
    logic [SW-1:0]        stage_idx;
    logic                 busy;
    logic                 ntt_done;

`ifdef R16_AGU_INTT_EN
    modport master (
        input  start, stall, intt,
        output ma_idx, bn_idx, ntt_enable, stage_idx, busy, ntt_done
    );
    modport slave (
        output start, stall, intt,
        input  ma_idx, bn_idx, ntt_enable, stage_idx, busy, ntt_done
    );
`else
    modport master (
        input  start, stall,
        output ma_idx, bn_idx, ntt_enable, stage_idx, busy, ntt_done
    );
    modport slave (
        output start, stall,
        input  ma_idx, bn_idx, ntt_enable, stage_idx, busy, ntt_done
    );
`endif
endinterface

// File: rtl/r16_agu.sv
// r16_agu: radix-16 NTT address generator issuing 16 conflict-free MA/BN lanes per cycle.
// Define R16_AGU_INTT_EN to add the intt input selecting ascending (inverse) digit order.
module r16_agu #(
    parameter int STAGES   = 3,
    parameter int GAP_CYC  = 12,
    parameter int PIPE_LAT = 12
) (
    input logic       clk,
    input logic       rst,
    r16_agu_if.master bus
);
    localparam int MA_W  = 4 * (STAGES - 1);
    localparam int IDX_W = 4 * STAGES;
    localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int CNT_W = 16;
    localparam int J_MAX = (1 << MA_W) - 1;
    localparam logic [MA_W-1:0] J_LAST = MA_W'(J_MAX);
    localparam logic [SW-1:0]   S_LAST = SW'(STAGES - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

    state_t             state, state_n;
    logic [SW-1:0]      s, s_n;
    logic [MA_W-1:0]    j, j_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               dir, dir_n;
    logic               issue, done_n;

    logic [16*MA_W-1:0] ma_q, issue_ma;
    logic [63:0]        bn_q, issue_bn;
    logic [SW-1:0]      stage_q;
    logic               en_q, done_q;

    int                 dig_pos;
    logic [IDX_W-1:0]   jx, low_mask, idx;
    logic [3:0]         digit_sum;

    // Lane k's element index is j with k spliced in as base-16 digit dig_pos;
    // the bank is the digit sum mod 16, which makes the 16 lanes hit distinct banks.
    always_comb begin
        issue_ma  = '0;
        issue_bn  = '0;
        idx       = '0;
        digit_sum = '0;
        jx        = IDX_W'(j);
        dig_pos   = dir ? int'(s) : (STAGES - 1 - int'(s));
        low_mask  = (IDX_W'(1) << (4 * dig_pos)) - IDX_W'(1);
        for (int k = 0; k < 16; k++) begin
            idx = (jx & low_mask) | (IDX_W'(k) << (4 * dig_pos)) | ((jx & ~low_mask) << 4);
            digit_sum = '0;
            for (int d = 0; d < STAGES; d++) begin
                digit_sum = digit_sum + idx[4*d +: 4];
            end
            issue_ma[k*MA_W +: MA_W] = idx[IDX_W-1:4];
            issue_bn[k*4 +: 4]       = digit_sum;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        j_n     = j;
        cnt_n   = cnt;
        dir_n   = dir;
        issue   = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                    s_n     = '0;
                    j_n     = '0;
                    cnt_n   = '0;
`ifdef R16_AGU_INTT_EN
                    dir_n   = bus.intt;
`else
                    dir_n   = 1'b0;
`endif
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    issue = 1'b1;
                    if (j != J_LAST) begin
                        j_n = j + 1'b1;
                    end else if (s != S_LAST) begin
                        j_n     = '0;
                        s_n     = s + 1'b1;
                        cnt_n   = '0;
                        state_n = (GAP_CYC == 0) ? RUN : GAP;
                    end else begin
                        cnt_n = '0;
                        if (PIPE_LAT == 0) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = DRAIN;
                        end
                    end
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(PIPE_LAT - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Index outputs only update on an issue so a stalled butterfly stays on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s       <= '0;
            j       <= '0;
            cnt     <= '0;
            dir     <= 1'b0;
            ma_q    <= '0;
            bn_q    <= '0;
            stage_q <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_n;
            s      <= s_n;
            j      <= j_n;
            cnt    <= cnt_n;
            dir    <= dir_n;
            en_q   <= issue;
            done_q <= done_n;
            if (issue) begin
                ma_q    <= issue_ma;
                bn_q    <= issue_bn;
                stage_q <= s;
            end
        end
    end

    assign bus.ma_idx     = ma_q;
    assign bus.bn_idx     = bn_q;
    assign bus.ntt_enable = en_q;
    assign bus.stage_idx  = stage_q;
    assign bus.ntt_done   = done_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_r16_agu.sv
// tb_r16_agu: randomized self-checking bench for r16_agu against a digit-arithmetic model.
// Exercises the intt path too when built with R16_AGU_INTT_EN.
module tb_r16_agu;
    localparam int STAGES   = 3;
    localparam int GAP_CYC  = 12;
    localparam int PIPE_LAT = 12;
    localparam int MA_W     = 8;
    localparam int SW       = 2;
    localparam int JN       = 256;
    localparam int TOTAL    = 768;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    r16_agu_if #(.STAGES(STAGES)) bus ();

    r16_agu #(
        .STAGES  (STAGES),
        .GAP_CYC (GAP_CYC),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int fails  = 0;
    int en_count = 0;
    bit check_en = 1'b0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Element index = j with lane k inserted as base-16 digit p; bank = digit sum mod 16.
    function automatic void lanes(input int s, input int j, input bit inv,
                                  output logic [127:0] ma, output logic [63:0] bn);
        int p, w, idx, t, sum;
        ma = '0;
        bn = '0;
        p = inv ? s : (STAGES - 1 - s);
        w = 16 ** p;
        for (int k = 0; k < 16; k++) begin
            idx = (j / w) * w * 16 + k * w + (j % w);
            t = idx;
            sum = 0;
            for (int d = 0; d < STAGES; d++) begin
                sum += t % 16;
                t = t / 16;
            end
            ma[k*MA_W +: MA_W] = MA_W'(idx / 16);
            bn[k*4 +: 4]       = 4'(sum % 16);
        end
    endfunction

    int           m_n, m_wait, m_s, m_j;
    bit           m_busy, m_dir;
    logic [127:0] exp_ma;
    logic [63:0]  exp_bn;
    logic [SW-1:0] exp_stage;
    bit           exp_en, exp_done;

    // Model: a transform is TOTAL issues taken in order, one per non-stalled window cycle,
    // with a fixed idle wait after every JN issues (gap, or drain after the last).
    always @(posedge clk) begin
        exp_en   = 1'b0;
        exp_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_n = 0; m_wait = 0; m_dir = 1'b0; m_s = 0; m_j = 0;
            exp_ma = '0; exp_bn = '0; exp_stage = '0;
        end else if (!m_busy) begin
            if (bus.start) begin
                m_busy = 1'b1; m_n = 0; m_wait = 0;
`ifdef R16_AGU_INTT_EN
                m_dir = bus.intt;
`else
                m_dir = 1'b0;
`endif
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0 && m_n == TOTAL) begin
                m_busy   = 1'b0;
                exp_done = 1'b1;
            end
        end else if (!bus.stall) begin
            m_s = m_n / JN;
            m_j = m_n % JN;
            lanes(m_s, m_j, m_dir, exp_ma, exp_bn);
            exp_stage = SW'(m_s);
            exp_en = 1'b1;
            m_n++;
            if (m_n % JN == 0) m_wait = (m_n == TOTAL) ? PIPE_LAT : GAP_CYC;
        end
    end

    logic [127:0] lit_ma;
    logic [63:0]  lit_bn;
    logic [15:0]  seen;
    bit           pin;

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("ntt_enable", 128'(bus.ntt_enable), 128'(exp_en));
            checkOutput("ntt_done", 128'(bus.ntt_done), 128'(exp_done));
            checkOutput("busy", 128'(bus.busy), 128'(m_busy));
            checkOutput("stage_idx", 128'(bus.stage_idx), 128'(exp_stage));
            checkOutput("ma_idx", bus.ma_idx, exp_ma);
            checkOutput("bn_idx", 128'(bus.bn_idx), 128'(exp_bn));
            if (bus.ntt_enable === 1'b1) begin
                en_count++;
                seen = '0;
                for (int k = 0; k < 16; k++) seen[bus.bn_idx[k*4 +: 4]] = 1'b1;
                checkOutput("bn_distinct", 128'($countones(seen)), 128'(16));
                pin = 1'b1;
                lit_ma = '0;
                lit_bn = '0;
                for (int k = 0; k < 16; k++) begin
                    if (m_dir) begin
                        lit_ma[k*MA_W +: MA_W] = 8'd0;
                        lit_bn[k*4 +: 4] = 4'(k);
                    end else if (m_s == 0 && m_j == 0) begin
                        lit_ma[k*MA_W +: MA_W] = 8'(16 * k);
                        lit_bn[k*4 +: 4] = 4'(k);
                    end else if (m_s == 0 && m_j == 1) begin
                        lit_ma[k*MA_W +: MA_W] = 8'(16 * k);
                        lit_bn[k*4 +: 4] = 4'((k + 1) % 16);
                    end else if (m_s == 1 && m_j == 'h12) begin
                        lit_ma[k*MA_W +: MA_W] = 8'('h10 + k);
                        lit_bn[k*4 +: 4] = 4'((k + 3) % 16);
                    end else if (m_s == 2 && m_j == 0) begin
                        lit_ma[k*MA_W +: MA_W] = 8'd0;
                        lit_bn[k*4 +: 4] = 4'(k);
                    end else begin
                        pin = 1'b0;
                    end
                end
                if (pin && (!m_dir || (m_s == 0 && m_j == 0))) begin
                    checkOutput("pin_ma", bus.ma_idx, lit_ma);
                    checkOutput("pin_bn", 128'(bus.bn_idx), 128'(lit_bn));
                end
            end
        end
    end

    task automatic applyStimulus(input logic st, input logic sl, input logic rs);
        bus.start = st;
        bus.stall = sl;
        rst = rs;
        @(posedge clk);
        #1;
    endtask

    // mode 0: no stall; 1: stall for 5 cycles over s=0 j=100; 2: random stall and start
    task automatic waitDone(input int mode, output int cyc);
        cyc = -1;
        for (int c = 1; c <= 4000; c++) begin
            logic sl, st;
            sl = 1'b0;
            st = 1'b0;
            if (mode == 1) begin
                sl = (c >= 101 && c <= 105);
            end else if (mode == 2) begin
                sl = ($urandom_range(0, 3) == 0);
                st = ($urandom_range(0, 7) == 0);
            end
            applyStimulus(st, sl, 1'b0);
            if (bus.ntt_done === 1'b1) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL done_timeout: no ntt_done within 4000 cycles, required a pulse");
        end else begin
            checkOutput("busy_at_done", 128'(bus.busy), 128'(0));
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("done_one_cycle", 128'(bus.ntt_done), 128'(0));
        end
    endtask

    int cyc;

    initial begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rst = 1'b1;
`ifdef R16_AGU_INTT_EN
        bus.intt = 1'b0;
`endif
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        check_en = 1'b1;
        checkOutput("reset_enable", 128'(bus.ntt_enable), 128'(0));
        checkOutput("reset_busy", 128'(bus.busy), 128'(0));
        checkOutput("reset_done", 128'(bus.ntt_done), 128'(0));
        checkOutput("reset_ma", bus.ma_idx, 128'(0));
        checkOutput("reset_bn", 128'(bus.bn_idx), 128'(0));
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] full run without stall");
        en_count = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("busy_after_start", 128'(bus.busy), 128'(1));
        checkOutput("no_issue_at_start", 128'(bus.ntt_enable), 128'(0));
        waitDone(0, cyc);
        checkOutput("done_cycle_nostall", 128'(cyc), 128'(804));
        checkOutput("enable_count", 128'(en_count), 128'(768));

        $display("[TB] run with 5-cycle stall at j=100");
        en_count = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(1, cyc);
        checkOutput("done_cycle_stall5", 128'(cyc), 128'(809));
        checkOutput("enable_count_stall", 128'(en_count), 128'(768));

        $display("[TB] reset at stage 1 j=50");
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 2000 && !(m_n == JN + 50 && m_wait == 0); c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("stage1_reached", 128'(bus.stage_idx), 128'(1));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_enable", 128'(bus.ntt_enable), 128'(0));
        checkOutput("abort_busy", 128'(bus.busy), 128'(0));
        checkOutput("abort_ma", bus.ma_idx, 128'(0));
        checkOutput("abort_bn", 128'(bus.bn_idx), 128'(0));
        checkOutput("abort_stage", 128'(bus.stage_idx), 128'(0));
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] start with stall held");
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("stalled_start_busy", 128'(bus.busy), 128'(1));
        checkOutput("stalled_start_enable", 128'(bus.ntt_enable), 128'(0));
        waitDone(0, cyc);
        checkOutput("done_cycle_stalled_start", 128'(cyc), 128'(804));

        $display("[TB] randomized stall/start runs");
        repeat (2) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            waitDone(2, cyc);
        end

`ifdef R16_AGU_INTT_EN
        $display("[TB] inverse order run");
        bus.intt = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        bus.intt = 1'b0;
        waitDone(2, cyc);
`endif

        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
